// File: rtl/bcd_display_scanner_if.sv
// Bus between the BCD counter chain / control logic and the display scanner.
// The master drives the digit data and control strobes; the slave (the
// scanner) drives the 7-segment pins, the digit enables and the status flag.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bcd_in_i;
  logic                    latch_i;
  logic                    blank_lz_i;
  logic                    ovf_i;
  logic                    clr_ovf_i;
  logic [6:0]              seg_o;
  logic                    dp_o;
  logic [NUM_DIGITS-1:0]   digit_en_o;
  logic                    bad_digit_o;

  modport master (
    output bcd_in_i, latch_i, blank_lz_i, ovf_i, clr_ovf_i,
    input  seg_o, dp_o, digit_en_o, bad_digit_o
  );

  modport slave (
    input  bcd_in_i, latch_i, blank_lz_i, ovf_i, clr_ovf_i,
    output seg_o, dp_o, digit_en_o, bad_digit_o
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner for a chain of cascaded BCD counters.
// A shadow copy of the digits is taken on latch; the scanner then walks the
// digits one at a time, SCAN_DIV cycles each, driving a shared segment bus
// with a one-hot digit enable. Leading zeros can be blanked, codes above 9
// are shown as a dash and flagged, and the overflow flag lights the decimal
// point of the most-significant digit. All pin outputs are registered.
module bcd_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_display_scanner_if.slave  bus
);

  localparam int PW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Pin polarity masks: XOR with these turns logical levels into pin levels.
  localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};
  localparam logic                  DP_POL  = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] EN_POL  = {NUM_DIGITS{ACTIVE_LOW}};

  // 7-segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // True when any nibble of the word holds a code above 9.
  function automatic logic any_illegal(input logic [4*NUM_DIGITS-1:0] v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hit = hit | (v[4*i +: 4] > 4'd9);
    end
    return hit;
  endfunction

  logic [PW-1:0]           presc_q;
  logic [IW-1:0]           idx_q;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic                    ovf_q;
  logic                    bad_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [NUM_DIGITS-1:0]   lz_s;
  logic [3:0]              sel_digit_s;
  logic                    tick_s;

  assign tick_s = (presc_q == PRESC_LAST);

  // Prescaler and scan index: the index steps once every SCAN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      if (tick_s) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  // Shadow digits, sticky illegal-code flag and overflow flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      bad_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (bus.latch_i) begin
        shadow_q <= bus.bcd_in_i;
        bad_q    <= bad_q | any_illegal(bus.bcd_in_i);
      end
      if (bus.ovf_i) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Leading-zero mask: bit i set when digit i and every higher digit are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_s     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow_q[4*i +: 4] == 4'd0);
      lz_s[i]  = zero_run;
    end
  end

  // Next pin values for the digit currently selected by the scan index.
  always_comb begin
    sel_digit_s = shadow_q[{idx_q, 2'b00} +: 4];
    if (bus.blank_lz_i && (idx_q != '0) && lz_s[idx_q]) begin
      seg_d = 7'h00 ^ SEG_POL;
    end else begin
      seg_d = seg_decode(sel_digit_s) ^ SEG_POL;
    end
    dp_d = (ovf_q && (idx_q == IDX_LAST)) ^ DP_POL;
    en_d = (NUM_DIGITS'(1) << idx_q) ^ EN_POL;
  end

  // Output registers; reset leaves every pin at its inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_POL;
      dp_q  <= DP_POL;
      en_q  <= EN_POL;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      en_q  <= en_d;
    end
  end

  assign bus.seg_o       = seg_q;
  assign bus.dp_o        = dp_q;
  assign bus.digit_en_o  = en_q;
  assign bus.bad_digit_o = bad_q;

endmodule
